// File: rtl/fwd_sched.sv
// Forwarding and hazard scheduler for the EX operand select muxes.
// Shadows the destination of every in-flight instruction and produces
// registered operand selects, load-use stalls and memory-wait freezes.
//
// state   | meaning
// --------+------------------------------------------------------------
// RUN     | normal flow, one instruction may enter EX per cycle
// LDSTALL | bubble was inserted last cycle, load result now in MEM
// MEMWAIT | load in MEM waiting on data memory, whole pipe frozen
module fwd_sched #(
  parameter int REGW = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_rs_used,
  input  logic            id_rt_used,
  input  logic            id_use_imm,
  input  logic [REGW-1:0] id_rd,
  input  logic            id_regwrite,
  input  logic            id_memtoreg,
  input  logic            flush,
  input  logic            mem_ready,
  output logic            stall_f,
  output logic            stall_d,
  output logic            bubble_e,
  output logic            freeze,
  output logic [2:0]      fwd_a_s,
  output logic [2:0]      fwd_b_s,
  output logic [1:0]      state,
  output logic [CNTW-1:0] stall_cnt
);

  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_LDSTALL = 2'b01;
  localparam logic [1:0] ST_MEMWAIT = 2'b10;

  localparam logic [2:0] SEL_RF  = 3'b000;
  localparam logic [2:0] SEL_MEM = 3'b001;
  localparam logic [2:0] SEL_WB  = 3'b010;
  localparam logic [2:0] SEL_LT  = 3'b011;
  localparam logic [2:0] SEL_IMM = 3'b100;

  // Shadow slots. A write that has left the WB slot is already visible
  // through the register file by the time a consumer reads it, so no
  // slot storage is needed beyond WB.
  logic            ex_v, ex_wr, ex_ld;
  logic [REGW-1:0] ex_rd;
  logic            mem_v, mem_wr, mem_ld;
  logic [REGW-1:0] mem_rd;
  logic            wb_v, wb_wr;
  logic [REGW-1:0] wb_rd;

  // Flush seen while frozen, applied to the next instruction that moves.
  logic            flush_lat;

  logic            flush_eff;
  logic            mem_wait;
  logic            a_ex, a_mem, a_wb;
  logic            b_ex, b_mem, b_wb;
  logic            ld_hazard;
  logic            ld_stall;
  logic            kill;
  logic [2:0]      sel_a, sel_b;
  logic [1:0]      state_nxt;

  assign flush_eff = flush | flush_lat;
  assign mem_wait  = mem_v & mem_ld & ~mem_ready;

  assign a_ex  = id_rs_used & (id_rs != '0) & ex_v  & ex_wr  & (ex_rd  == id_rs);
  assign a_mem = id_rs_used & (id_rs != '0) & mem_v & mem_wr & (mem_rd == id_rs);
  assign a_wb  = id_rs_used & (id_rs != '0) & wb_v  & wb_wr  & (wb_rd  == id_rs);
  assign b_ex  = id_rt_used & (id_rt != '0) & ex_v  & ex_wr  & (ex_rd  == id_rt);
  assign b_mem = id_rt_used & (id_rt != '0) & mem_v & mem_wr & (mem_rd == id_rt);
  assign b_wb  = id_rt_used & (id_rt != '0) & wb_v  & wb_wr  & (wb_rd  == id_rt);

  assign ld_hazard = id_valid & ~flush_eff & ex_ld & (a_ex | b_ex);
  // A memory wait freezes everything, so a pending load-use is simply retried later.
  assign ld_stall  = ld_hazard & ~mem_wait;
  assign kill      = ~id_valid | flush_eff | ld_stall;

  assign freeze   = mem_wait;
  assign stall_f  = mem_wait | ld_stall;
  assign stall_d  = mem_wait | ld_stall;
  assign bubble_e = ld_stall;

  // Operand selects for the ID instruction, nearest producer wins.
  always_comb begin
    sel_a = SEL_RF;
    if (a_ex)       sel_a = SEL_MEM;
    else if (a_mem) sel_a = SEL_WB;
    else if (a_wb)  sel_a = SEL_LT;

    sel_b = SEL_RF;
    if (id_use_imm) sel_b = SEL_IMM;
    else if (b_ex)  sel_b = SEL_MEM;
    else if (b_mem) sel_b = SEL_WB;
    else if (b_wb)  sel_b = SEL_LT;
  end

  // Next state: memory wait from anywhere, otherwise load-use, otherwise run.
  always_comb begin
    state_nxt = ST_RUN;
    if (mem_wait)      state_nxt = ST_MEMWAIT;
    else if (ld_stall) state_nxt = ST_LDSTALL;
  end

  // Slot shifting, select registers, flush latch, FSM and stall counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_v      <= 1'b0;
      ex_wr     <= 1'b0;
      ex_ld     <= 1'b0;
      ex_rd     <= '0;
      mem_v     <= 1'b0;
      mem_wr    <= 1'b0;
      mem_ld    <= 1'b0;
      mem_rd    <= '0;
      wb_v      <= 1'b0;
      wb_wr     <= 1'b0;
      wb_rd     <= '0;
      flush_lat <= 1'b0;
      fwd_a_s   <= SEL_RF;
      fwd_b_s   <= SEL_RF;
      state     <= ST_RUN;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_lat <= mem_wait & (flush_lat | flush);
      if (stall_d && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNTW'(1);
      if (!mem_wait) begin
        wb_v    <= mem_v;
        wb_wr   <= mem_wr;
        wb_rd   <= mem_rd;
        mem_v   <= ex_v;
        mem_wr  <= ex_wr;
        mem_ld  <= ex_ld;
        mem_rd  <= ex_rd;
        ex_v    <= ~kill;
        ex_wr   <= id_regwrite;
        ex_ld   <= id_memtoreg;
        ex_rd   <= id_rd;
        fwd_a_s <= kill ? SEL_RF : sel_a;
        fwd_b_s <= kill ? SEL_RF : sel_b;
      end
    end
  end

endmodule

// File: tb/tb_fwd_sched.sv
// Bench for fwd_sched: directed scenarios followed by random traffic, all
// checked against an instruction-list model of the pipeline.
module tb_fwd_sched;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_rs_used, id_rt_used, id_use_imm;
  logic       id_regwrite, id_memtoreg;
  logic       flush, mem_ready;
  logic       stall_f, stall_d, bubble_e, freeze;
  logic [2:0] fwd_a_s, fwd_b_s;
  logic [1:0] state;
  logic [15:0] stall_cnt;

  logic       s_stall_f, s_stall_d, s_bubble_e, s_freeze;
  logic [2:0] s_fwd_a_s, s_fwd_b_s;
  logic [1:0] s_state;
  logic [3:0] s_stall_cnt;

  always #5 clk = ~clk;

  fwd_sched dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_use_imm(id_use_imm),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
    .flush(flush), .mem_ready(mem_ready), .stall_f(stall_f), .stall_d(stall_d),
    .bubble_e(bubble_e), .freeze(freeze), .fwd_a_s(fwd_a_s), .fwd_b_s(fwd_b_s),
    .state(state), .stall_cnt(stall_cnt)
  );

  // Narrow counter copy so saturation is reachable in a short run.
  fwd_sched #(.REGW(5), .CNTW(4)) u_sat (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_use_imm(id_use_imm),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
    .flush(flush), .mem_ready(mem_ready), .stall_f(s_stall_f), .stall_d(s_stall_d),
    .bubble_e(s_bubble_e), .freeze(s_freeze), .fwd_a_s(s_fwd_a_s), .fwd_b_s(s_fwd_b_s),
    .state(s_state), .stall_cnt(s_stall_cnt)
  );

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } slot_t;

  // Model: mp[k] is the instruction k+1 stages beyond ID (0 = EX).
  slot_t      mp [3];
  logic       m_lat;
  logic [2:0] m_sa, m_sb;
  logic [1:0] m_state;
  int         m_cnt, m_cnt4;
  bit         mv = 0;

  int n_cmp = 0;
  int n_bad = 0;
  int c0;

  function automatic bit writes(slot_t s, logic [4:0] r);
    return (r != 5'd0) && s.v && s.wr && (s.rd == r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ins(input logic [4:0] rs, input logic [4:0] rt, input logic rsu,
                     input logic rtu, input logic imm, input logic [4:0] rd,
                     input logic wr, input logic ld);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
    id_use_imm = imm; id_rd = rd; id_regwrite = wr; id_memtoreg = ld;
  endtask

  task automatic nop();
    id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_rs_used = 1'b0; id_rt_used = 1'b0;
    id_use_imm = 1'b0; id_rd = 5'd0; id_regwrite = 1'b0; id_memtoreg = 1'b0;
  endtask

  // One clock: check combinational outputs mid-cycle, step the model at the
  // edge, then check registered outputs just after it.
  task automatic cyc();
    logic fl, mw, dep, hz, kill;
    logic [2:0] sa, sb;
    fl  = flush | m_lat;
    mw  = mp[1].v && mp[1].ld && !mem_ready;
    dep = id_valid && !fl && mp[0].ld &&
          ((id_rs_used && writes(mp[0], id_rs)) || (id_rt_used && writes(mp[0], id_rt)));
    hz  = dep && !mw;
    @(negedge clk);
    if (mv) begin
      chk("freeze", freeze, mw);
      chk("stall_f", stall_f, mw | hz);
      chk("stall_d", stall_d, mw | hz);
      chk("bubble_e", bubble_e, hz);
    end
    @(posedge clk);
    if (!reset_n) begin
      for (int k = 0; k < 3; k++) mp[k] = '0;
      m_lat = 1'b0; m_sa = 3'd0; m_sb = 3'd0; m_state = 2'd0; m_cnt = 0; m_cnt4 = 0;
      mv = 1;
    end else if (mv) begin
      if (mw || hz) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (mw) begin
        m_state = 2'd2;
        m_lat = m_lat | flush;
      end else begin
        m_state = hz ? 2'd1 : 2'd0;
        sa = 3'd0; sb = 3'd0;
        for (int k = 2; k >= 0; k--) begin
          if (id_rs_used && writes(mp[k], id_rs)) sa = 3'(k + 1);
          if (id_rt_used && writes(mp[k], id_rt)) sb = 3'(k + 1);
        end
        if (id_use_imm) sb = 3'd4;
        kill = !id_valid || fl || hz;
        m_sa = kill ? 3'd0 : sa;
        m_sb = kill ? 3'd0 : sb;
        mp[2] = mp[1];
        mp[1] = mp[0];
        mp[0] = '{v: !kill, rd: id_rd, wr: id_regwrite, ld: id_memtoreg};
        m_lat = 1'b0;
      end
    end
    #1;
    if (mv) begin
      chk("fwd_a_s", fwd_a_s, m_sa);
      chk("fwd_b_s", fwd_b_s, m_sb);
      chk("state", state, m_state);
      chk("stall_cnt", stall_cnt, m_cnt);
      chk("sat_cnt", s_stall_cnt, m_cnt4);
    end
  endtask

  task automatic drain(input int n);
    nop();
    repeat (n) cyc();
  endtask

  // add r3; lw r5; X reads r3 and writes r9. Leaves the load in MEM.
  task automatic load_in_mem();
    ins(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0); cyc();
    ins(5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1); cyc();
    ins(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0); cyc();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) mp[k] = '0;
    m_lat = 1'b0; m_sa = 3'd0; m_sb = 3'd0; m_state = 2'd0; m_cnt = 0; m_cnt4 = 0;
    reset_n = 1'b0; flush = 1'b0; mem_ready = 1'b1;
    nop();
    cyc(); cyc();
    chk("rst_state", state, 2'b00);
    chk("rst_fwd_a", fwd_a_s, 3'b000);
    chk("rst_cnt", stall_cnt, 16'h0000);
    reset_n = 1'b1;

    // Back-to-back ALU dependency
    ins(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0); cyc();
    ins(5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0); cyc();
    chk("t1_fwd_a", fwd_a_s, 3'b001);
    chk("t1_fwd_b", fwd_b_s, 3'b001);
    chk("t1_nostall", state, 2'b00);

    // Load-use
    drain(3);
    ins(5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1); cyc();
    ins(5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    #1;
    chk("t2_bubble", bubble_e, 1'b1);
    chk("t2_stall_d", stall_d, 1'b1);
    cyc();
    chk("t2_state", state, 2'b01);
    cyc();
    chk("t2_fwd_a", fwd_a_s, 3'b010);
    chk("t2_fwd_b", fwd_b_s, 3'b000);
    chk("t2_back_run", state, 2'b00);

    // Distance-3 producer and r0
    drain(3);
    ins(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0); cyc();
    ins(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0); cyc();
    ins(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0); cyc();
    ins(5'd7, 5'd2, 1'b1, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0); cyc();
    chk("t3_late", fwd_a_s, 3'b011);
    ins(5'd1, 5'd1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0); cyc();
    ins(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0); cyc();
    chk("t3_r0_a", fwd_a_s, 3'b000);
    chk("t3_r0_b", fwd_b_s, 3'b000);

    // Memory wait for three cycles
    drain(3);
    load_in_mem();
    chk("t4_pre_sel", fwd_a_s, 3'b010);
    c0 = m_cnt;
    mem_ready = 1'b0;
    ins(5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd13, 1'b1, 1'b0);
    repeat (3) begin
      cyc();
      chk("t4_freeze", freeze, 1'b1);
      chk("t4_state", state, 2'b10);
      chk("t4_held", fwd_a_s, 3'b010);
    end
    chk("t4_cnt", stall_cnt, 16'(c0 + 3));
    mem_ready = 1'b1; cyc();
    chk("t4_exit", state, 2'b00);
    chk("t4_adv", fwd_a_s, 3'b001);

    // Flush while frozen
    drain(3);
    load_in_mem();
    mem_ready = 1'b0;
    ins(5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd11, 1'b1, 1'b0);
    flush = 1'b1; cyc();
    flush = 1'b0; cyc();
    mem_ready = 1'b1; cyc();
    chk("t5_kill_a", fwd_a_s, 3'b000);
    chk("t5_kill_b", fwd_b_s, 3'b000);
    ins(5'd11, 5'd0, 1'b1, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0); cyc();
    chk("t5_bubble", fwd_a_s, 3'b000);
    ins(5'd12, 5'd0, 1'b1, 1'b0, 1'b0, 5'd14, 1'b1, 1'b0); cyc();
    chk("t5_latch_clr", fwd_a_s, 3'b001);

    // Reset during load-use stall
    drain(3);
    ins(5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1); cyc();
    ins(5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0); cyc();
    chk("t6_ldstall", state, 2'b01);
    reset_n = 1'b0; cyc();
    chk("t6_state", state, 2'b00);
    chk("t6_cnt", stall_cnt, 16'h0000);
    chk("t6_sel", {fwd_a_s, fwd_b_s}, 6'd0);
    chk("t6_outs", {stall_f, stall_d, bubble_e, freeze}, 4'd0);
    reset_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset_n     = ($urandom_range(99) == 0) ? 1'b0 : 1'b1;
      id_valid    = ($urandom_range(9) != 0);
      id_rs       = 5'($urandom_range(7));
      id_rt       = 5'($urandom_range(7));
      id_rd       = 5'($urandom_range(7));
      id_rs_used  = 1'($urandom_range(1));
      id_rt_used  = 1'($urandom_range(1));
      id_use_imm  = ($urandom_range(3) == 0);
      id_regwrite = ($urandom_range(4) != 0);
      id_memtoreg = ($urandom_range(9) < 3);
      flush       = ($urandom_range(9) == 0);
      mem_ready   = ($urandom_range(9) < 7);
      cyc();
    end
    reset_n = 1'b1; flush = 1'b0; mem_ready = 1'b1;

    // Long freeze drives the narrow counter into saturation
    drain(3);
    load_in_mem();
    mem_ready = 1'b0;
    nop();
    repeat (20) cyc();
    chk("sat_max", s_stall_cnt, 4'hF);
    mem_ready = 1'b1;
    drain(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
